// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
// Shared definitions for the pipelined add/subtract unit:
//   ADD / SUB    - encoding of the 'sub' mode input
//   chunk_width  - width of one carry chunk, or 0 when SIZE/STAGES is not a
//                  legal split (STAGES outside 1..SIZE or not dividing SIZE)
package pipe_adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int chunk_width(input int size, input int stages);
    if (stages < 1 || stages > size || (size % stages) != 0) begin
      return 0;
    end
    return size / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage
// One pipeline stage of pipe_adder: a W-bit chunk adder plus the stage's
// valid bit and load enable.
//
// Data layout (both buses): the low SIZE bits hold the partially finished
// word -- completed sum bits below bit LO, unconsumed operand-A bits above.
// Bits from SIZE upward hold the unconsumed operand-B bits. Each stage
// replaces A chunk [LO +: W] with its sum and drops the consumed B chunk, so
// the outgoing bus is W bits narrower than the incoming one.
//
// Parameters:
//   SIZE - full operand width
//   W    - chunk width
//   HI   - operand bits still unconsumed after this stage (0 for the last)
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   up_valid    - upstream beat valid
//   up_carry    - carry into this chunk
//   up_data     - incoming bus, SIZE+W+HI bits
//   down_load   - downstream stage loads this cycle (out_ready for the last)
//   load        - this stage loads this cycle
//   valid       - stage holds a beat
//   carry       - registered carry out of this chunk
//   data        - registered outgoing bus, SIZE+HI bits
//   up_ovf/ovf  - overflow flag chain (only with PIPE_ADDER_OVF_EN)
module pipe_adder_stage #(
  parameter int SIZE = 8,
  parameter int W    = 4,
  parameter int HI   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  input  logic               up_carry,
  input  logic [SIZE+W+HI-1:0] up_data,
  input  logic               down_load,
  output logic               load,
  output logic               valid,
  output logic               carry,
  output logic [SIZE+HI-1:0] data
`ifdef PIPE_ADDER_OVF_EN
  ,
  input  logic               up_ovf,
  output logic               ovf
`endif
);

  localparam int LO = SIZE - W - HI;

  logic [W-1:0]       a_chunk;
  logic [W-1:0]       b_chunk;
  logic [W:0]         chunk_sum;
  logic [SIZE+HI-1:0] data_nxt;

  assign a_chunk   = up_data[LO +: W];
  assign b_chunk   = up_data[SIZE +: W];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, up_carry};

  // Shifting right by W drops the consumed B chunk and lines the remaining
  // B bits up at bit SIZE; the low SIZE bits are then restored from the
  // incoming word with this chunk's sum patched in.
  always_comb begin
    data_nxt               = (SIZE+HI)'(up_data >> W);
    data_nxt[SIZE-1:0]     = up_data[SIZE-1:0];
    data_nxt[LO +: W]      = chunk_sum[W-1:0];
  end

  // A stage can take new data when it is empty or its content moves on.
  assign load = !valid || down_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      carry <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        carry <= chunk_sum[W];
        data  <= data_nxt;
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Only the last chunk holds the MSB; earlier stages just forward the chain.
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  logic msb_carry_in;
  logic ovf_nxt;

  assign msb_carry_in = chunk_sum[W-1] ^ a_chunk[W-1] ^ b_chunk[W-1];
  assign ovf_nxt      = (HI == 0) ? (msb_carry_in ^ chunk_sum[W]) : up_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (load && up_valid) begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
// Pipelined SIZE-bit add/subtract unit split into STAGES carry chunks with
// one register stage per chunk and valid/ready flow control on both sides.
//   add: {co,sum} = a + b + ci
//   sub: {co,sum} = a + ~b + ~ci  (a - b - ci, co = 1 means no borrow)
// Optional feature macro: PIPE_ADDER_OVF_EN adds the registered signed
// overflow output 'ovf'.
//
// Parameters:
//   SIZE   - operand/result width
//   STAGES - pipeline depth; must divide SIZE, 1 <= STAGES <= SIZE
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - operand handshake
//   a, b, ci, sub       - operands, carry/borrow-in, mode (0 add, 1 sub)
//   out_valid, out_ready- result handshake
//   sum, co             - result and carry-out
//   ovf                 - signed overflow (PIPE_ADDER_OVF_EN only)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] sum,
  output logic            co
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam int W = chunk_width(SIZE, STAGES);

  if (W == 0) begin : g_bad_cfg
    $error("pipe_adder: STAGES must divide SIZE and lie in 1..SIZE");
  end

  logic [SIZE-1:0] b_eff;
  logic            c_eff;

  always_comb begin
    b_eff = b;
    c_eff = ci;
    case (sub)
      ADD: begin
        b_eff = b;
        c_eff = ci;
      end
      SUB: begin
        b_eff = ~b;
        c_eff = ~ci;
      end
    endcase
  end

  // Index k is the input side of stage k; index STAGES is the output side.
  logic [STAGES:0] vld;
  logic [STAGES:0] ld;
  logic [STAGES:0] cy;

  assign vld[0]     = in_valid;
  assign cy[0]      = c_eff;
  assign ld[STAGES] = out_ready;

`ifdef PIPE_ADDER_OVF_EN
  logic [STAGES:0] ov;
  assign ov[0] = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = SIZE - (k + 1) * W;

    logic [SIZE+W+HI-1:0] d_in;
    logic [SIZE+HI-1:0]   d_q;

    if (k == 0) begin : g_first
      assign d_in = {b_eff, a};
    end else begin : g_next
      assign d_in = g_stage[k-1].d_q;
    end

    pipe_adder_stage #(
      .SIZE (SIZE),
      .W    (W),
      .HI   (HI)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (vld[k]),
      .up_carry  (cy[k]),
      .up_data   (d_in),
      .down_load (ld[k+1]),
      .load      (ld[k]),
      .valid     (vld[k+1]),
      .carry     (cy[k+1]),
      .data      (d_q)
`ifdef PIPE_ADDER_OVF_EN
      ,
      .up_ovf    (ov[k]),
      .ovf       (ov[k+1])
`endif
    );
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[STAGES];
  assign co        = cy[STAGES];
  assign sum       = g_stage[STAGES-1].d_q;

`ifdef PIPE_ADDER_OVF_EN
  assign ovf = ov[STAGES];
`endif

endmodule
